// File: rtl/count_ctrl.sv
// count_ctrl: button front end for the 3-bit up/down counter.
// Synchronises and debounces two raw buttons, then emits one registered count pulse
// per press (plus optional auto-repeat) together with a registered direction level.
module count_ctrl #(
  parameter int unsigned DEBOUNCE = 4,  // 1..255 cycles of stable difference before a flip
  parameter int unsigned REPEAT   = 8   // 0 = no auto-repeat, else 2..255 cycle period
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_up,
  input  logic btn_down,
  output logic count,
  output logic inc,
  output logic locked
);

  localparam logic [7:0] DbLast = 8'(DEBOUNCE - 1);
  localparam logic [7:0] RpLast = (REPEAT == 0) ? 8'd0 : 8'(REPEAT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StHoldUp,
    StHoldDn,
    StLock
  } state_e;

  // Bit 0 carries the up button, bit 1 the down button throughout.
  logic [1:0] raw;
  logic [1:0] sync1;
  logic [1:0] sync2;
  logic [1:0] deb;
  logic [7:0] db_cnt [2];
  logic       up_d;
  logic       dn_d;

  state_e     state;
  logic [7:0] rpt_cnt;

  assign raw  = {btn_down, btn_up};
  assign up_d = deb[0];
  assign dn_d = deb[1];

  // Two-flop synchroniser per button.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Debounce: flip only after DEBOUNCE consecutive cycles of disagreement.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb       <= '0;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DbLast) begin
          deb[i]    <= ~deb[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 8'd1;
        end
      end
    end
  end

  // Press FSM with registered pulse, direction and lock outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= StIdle;
      rpt_cnt <= '0;
      count   <= 1'b0;
      inc     <= 1'b0;
      locked  <= 1'b0;
    end else begin
      count <= 1'b0;
      unique case (state)
        StIdle: begin
          if (up_d && dn_d) begin
            state  <= StLock;
            locked <= 1'b1;
          end else if (up_d) begin
            state   <= StHoldUp;
            count   <= 1'b1;
            inc     <= 1'b1;
            rpt_cnt <= '0;
          end else if (dn_d) begin
            state   <= StHoldDn;
            count   <= 1'b1;
            inc     <= 1'b0;
            rpt_cnt <= '0;
          end
        end
        StHoldUp: begin
          // A second button wins over release and repeat.
          if (dn_d) begin
            state  <= StLock;
            locked <= 1'b1;
          end else if (!up_d) begin
            state <= StIdle;
          end else if (REPEAT != 0) begin
            if (rpt_cnt == RpLast) begin
              count   <= 1'b1;
              inc     <= 1'b1;
              rpt_cnt <= '0;
            end else begin
              rpt_cnt <= rpt_cnt + 8'd1;
            end
          end
        end
        StHoldDn: begin
          if (up_d) begin
            state  <= StLock;
            locked <= 1'b1;
          end else if (!dn_d) begin
            state <= StIdle;
          end else if (REPEAT != 0) begin
            if (rpt_cnt == RpLast) begin
              count   <= 1'b1;
              inc     <= 1'b0;
              rpt_cnt <= '0;
            end else begin
              rpt_cnt <= rpt_cnt + 8'd1;
            end
          end
        end
        StLock: begin
          if (!up_d && !dn_d) begin
            state  <= StIdle;
            locked <= 1'b0;
          end
        end
        default: begin
          state  <= StIdle;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule
